sw_job_scheduler: RTL and testbench
===================================

# sw_job_scheduler

Front-end job scheduler for the Smith-Waterman PE-array controller. Arbitrates round-robin among `N_REQ` host requesters, latches each winner's scoring parameters, and holds them stable on the array's configuration inputs for the whole job. It pulses the array start and waits for the result pulse, then returns score, tag and status to the winning requester over a valid/ready response channel. It sits between the host/top-level bus and the PE-array controller, which is the only array-side client.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `MATCH_W`, 8: match-score width.
- `SCORE_W`, 16: V/E/F score width (mismatch, gap penalties, result).
- `TAG_W`, 4: opaque job tag width.
- `TIMEOUT_CYC`, 2^20: watchdog limit in cycles; used only with `SW_SCHED_TIMEOUT_EN`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  job request per requester.
- `req_ready`  out  N_REQ  one-hot grant; the job is accepted on `valid & ready`.
- `req_match`  in  N_REQ*MATCH_W  per-requester match score, packed, requester 0 in the LSBs.
- `req_mismatch`, `req_minus_alpha`, `req_minus_beta`  in  N_REQ*SCORE_W each  signed penalties, packed the same way.
- `req_tag`  in  N_REQ*TAG_W  job tag.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  host accepts the response.
- `resp_id`  out  $clog2(N_REQ)  index of the granted requester.
- `resp_tag`  out  TAG_W  tag of the accepted job.
- `resp_score`  out  SCORE_W  best local score.
- `resp_err`  out  2  status: 00 ok, 01 timeout, 10 parameter error.
- `o_match`  out  MATCH_W  to the array; held for the whole job.
- `o_mismatch`, `o_minus_alpha`, `o_minus_beta`  out  SCORE_W  to the array; held for the whole job.
- `o_start`  out  1  one-cycle start pulse to the array.
- `i_busy`  in  1  array busy.
- `i_valid`  in  1  one-cycle pulse qualifying `i_result`.
- `i_result`  in  SCORE_W  array best score.
- `o_abort`  out  1  one-cycle abort request to the array; present only with `SW_SCHED_TIMEOUT_EN`.

## Operation
- States:
  - IDLE: grant allowed.
  - LOAD: register the parameters.
  - START: pulse `o_start`.
  - RUN: wait for the result.
  - RESP: hold the response.
- IDLE:
  - Arbiter drives `req_ready` one-hot, combinationally from `req_valid` and the RR pointer.
  - The winner is the lowest index strictly after the last-granted index, with wrap-around.
  - If no requester is valid, `req_ready = 0`.
  - On accept: latch all fields and the id, update the pointer to the winner, go to LOAD.
- LOAD:
  - Parameter check, signed: `minus_alpha <= minus_beta`, `mismatch <= 0` and `match != 0`.
  - Check fails: `resp_err = 10`, `resp_score = 0`, go to RESP. The array is never started.
  - Check passes: go to START.
- START: `o_start = 1` for exactly this cycle; go to RUN.
- RUN:
  - On `i_valid`, capture `i_result` into `resp_score`, set `resp_err = 00`, go to RESP.
  - `i_busy` is status only; it is not a handshake term.
- RESP:
  - `resp_valid = 1`; all `resp_*` outputs stable until `resp_valid & resp_ready`.
  - On that handshake, go to IDLE.
- `i_valid` outside RUN is ignored.
- `o_match`/`o_mismatch`/`o_minus_*` change only on the LOAD edge. They keep their last value in IDLE.
- Reset values:
  - State IDLE, RR pointer = N_REQ-1 (requester 0 wins first).
  - `req_ready` 0.
  - All `resp_*` 0, `resp_valid` 0.
  - All `o_*` config outputs 0, `o_start` 0, `o_abort` 0.
- Reset mid-job returns to IDLE immediately and drops the job without a response.

## Timing
- Accept at edge T0.
  - LOAD during T0→T1; config outputs are valid from T1.
  - `o_start` is high during T1→T2, so parameters are stable at least one cycle before start.
- `i_valid` sampled at edge Tv → `resp_valid` high from Tv (a registered, one-cycle response).
- Parameter-error path: `resp_valid` rises 2 cycles after accept.
- Back-to-back: the earliest next grant is the cycle after the response handshake.
- Maximum throughput is one job per (array latency + 4) cycles.

## Configuration
- `SW_SCHED_TIMEOUT_EN` defined:
  - A counter counts RUN cycles.
  - On reaching `TIMEOUT_CYC` with no `i_valid`: pulse `o_abort` for 1 cycle, set `resp_err = 01`, `resp_score = 0`, go to RESP.
  - If `i_valid` arrives in the same cycle the limit is reached, `i_valid` wins and the response is ok.
  - The counter clears on entering RUN.
- `SW_SCHED_TIMEOUT_EN` undefined: no counter, no `o_abort` port, and RUN waits indefinitely. Error code 01 is never produced.

## Structure
- Package `sw_sched_pkg`:
  - State encoding.
  - Error codes `ERR_OK`/`ERR_TIMEOUT`/`ERR_PARAM`.
  - Default widths.
- Sub-module `sw_rr_arbiter`:
  - Parameterized by N_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Combinational; the pointer register lives in the parent.

## Test plan
- Single job:
  - Stimulus: requester 0 sends match=2, mismatch=-1, alpha=-3, beta=-1, tag=5; array returns `i_valid` with result 42.
  - Response: `o_start` exactly once, 2 cycles after accept; then resp id=0, tag=5, score=42, err=00.
- Round-robin:
  - Stimulus: both requesters held valid for 4 jobs.
  - Response: grants alternate 0,1,0,1; each requester's params appear on `o_*` for its own job only.
- Parameter error:
  - Stimulus: alpha=-1, beta=-3.
  - Response: err=10, score=0, no `o_start`, `resp_valid` 2 cycles after accept.
- Backpressure:
  - Stimulus: `resp_ready` held low 10 cycles while requester 1 is valid.
  - Response: the response stays stable and `req_ready` stays 0 until the handshake.
- Timeout (macro on, `TIMEOUT_CYC`=16):
  - Stimulus: no `i_valid` is ever returned.
  - Response: `o_abort` pulse 16 cycles after RUN entry, err=01.
  - Stimulus: a second run with `i_valid` on cycle 16.
  - Response: err=00.
- Reset:
  - Stimulus: `rst` asserted in RUN.
  - Response: all outputs at reset values; after release, requester 0 wins first.

Source files
------------

// File: rtl/sw_sched_pkg.sv
// Shared constants for the Smith-Waterman job scheduler: state encoding, status codes,
// default widths and a small modular-increment helper used by the arbiter.
package sw_sched_pkg;

  localparam int N_REQ_DEF       = 2;
  localparam int MATCH_W_DEF     = 8;
  localparam int SCORE_W_DEF     = 16;
  localparam int TAG_W_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 1 << 20;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_PARAM   = 2'b10;

  // v is at most 2*n-1, so one conditional subtract replaces a modulo.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// Round-robin grant: lowest requester strictly after ptr, wrapping; purely combinational,
// the pointer register lives in the parent. en low forces an all-zero grant.
module sw_rr_arbiter
  import sw_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     en,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(N_REQ);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == rr_wrap(int'(ptr) + off, N_REQ))) begin
          gnt[i] = 1'b1;
          idx    = ID_W'(i);
          found  = 1'b1;
        end
      end
    end
    if (!en) begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/sw_job_scheduler.sv
// Job front-end for the SW PE array: RR grant, param latch, start pulse, result; resp_valid 2 cycles
// after accept on param error, same edge as i_valid otherwise; holds in RESP until resp_ready. Watchdog: SW_SCHED_TIMEOUT_EN.
module sw_job_scheduler
  import sw_sched_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int MATCH_W     = MATCH_W_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*MATCH_W-1:0]   req_match,
  input  logic [N_REQ*SCORE_W-1:0]   req_mismatch,
  input  logic [N_REQ*SCORE_W-1:0]   req_minus_alpha,
  input  logic [N_REQ*SCORE_W-1:0]   req_minus_beta,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [SCORE_W-1:0]         resp_score,
  output logic [1:0]                 resp_err,
  output logic [MATCH_W-1:0]         o_match,
  output logic [SCORE_W-1:0]         o_mismatch,
  output logic [SCORE_W-1:0]         o_minus_alpha,
  output logic [SCORE_W-1:0]         o_minus_beta,
  output logic                       o_start,
  input  logic                       i_busy,
  input  logic                       i_valid,
  input  logic [SCORE_W-1:0]         i_result
`ifdef SW_SCHED_TIMEOUT_EN
 ,output logic                       o_abort
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("sw_job_scheduler: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef struct packed {
    logic [MATCH_W-1:0] match;
    logic [SCORE_W-1:0] mismatch;
    logic [SCORE_W-1:0] minus_alpha;
    logic [SCORE_W-1:0] minus_beta;
    logic [TAG_W-1:0]   tag;
  } job_t;

  logic [2:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_idx;
  logic [N_REQ-1:0] gnt;
  logic             accept;
  logic             param_ok;
  job_t             job;
  job_t             req_job [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_job[g].match       = req_match[g*MATCH_W +: MATCH_W];
    assign req_job[g].mismatch    = req_mismatch[g*SCORE_W +: SCORE_W];
    assign req_job[g].minus_alpha = req_minus_alpha[g*SCORE_W +: SCORE_W];
    assign req_job[g].minus_beta  = req_minus_beta[g*SCORE_W +: SCORE_W];
    assign req_job[g].tag         = req_tag[g*TAG_W +: TAG_W];
  end

  // Grants are masked while rst is high so req_ready shows its reset value immediately.
  sw_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  ((state == ST_IDLE) && !rst),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign req_ready  = gnt;
  assign accept     = |(req_valid & gnt);
  assign o_start    = (state == ST_START);
  assign resp_valid = (state == ST_RESP);

  // Signed check: alpha no larger than beta, mismatch non-positive, match nonzero.
  assign param_ok = ($signed(job.minus_alpha) <= $signed(job.minus_beta))
                 && (job.mismatch[SCORE_W-1] || (job.mismatch == '0))
                 && (job.match != '0);

  // i_busy is array status only and never gates the sequencing.
  logic unused_busy;
  assign unused_busy = i_busy;

`ifdef SW_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] run_cnt;
  logic             run_expired;
  assign run_expired = (run_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= ID_W'(N_REQ - 1);
      job           <= '0;
      resp_id       <= '0;
      resp_tag      <= '0;
      resp_score    <= '0;
      resp_err      <= ERR_OK;
      o_match       <= '0;
      o_mismatch    <= '0;
      o_minus_alpha <= '0;
      o_minus_beta  <= '0;
`ifdef SW_SCHED_TIMEOUT_EN
      run_cnt       <= '0;
      o_abort       <= 1'b0;
`endif
    end else begin
`ifdef SW_SCHED_TIMEOUT_EN
      o_abort <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            job      <= req_job[win_idx];
            resp_id  <= win_idx;
            resp_tag <= req_job[win_idx].tag;
            ptr      <= win_idx;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (param_ok) begin
            o_match       <= job.match;
            o_mismatch    <= job.mismatch;
            o_minus_alpha <= job.minus_alpha;
            o_minus_beta  <= job.minus_beta;
            state         <= ST_START;
          end else begin
            resp_err   <= ERR_PARAM;
            resp_score <= '0;
            state      <= ST_RESP;
          end
        end
        ST_START: begin
`ifdef SW_SCHED_TIMEOUT_EN
          run_cnt <= '0;
`endif
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_valid) begin
            resp_score <= i_result;
            resp_err   <= ERR_OK;
            state      <= ST_RESP;
          end
`ifdef SW_SCHED_TIMEOUT_EN
          else if (run_expired) begin
            o_abort    <= 1'b1;
            resp_score <= '0;
            resp_err   <= ERR_TIMEOUT;
            state      <= ST_RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Scoreboard bench for sw_job_scheduler: stimulus queues expected responses and array configs,
// independent monitors compare on response handshakes and start pulses.
module tb_sw_job_scheduler;

  localparam int N_REQ       = 2;
  localparam int MATCH_W     = 8;
  localparam int SCORE_W     = 16;
  localparam int TAG_W       = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [N_REQ-1:0]         req_valid = '0;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*MATCH_W-1:0] req_match = '0;
  logic [N_REQ*SCORE_W-1:0] req_mismatch = '0;
  logic [N_REQ*SCORE_W-1:0] req_minus_alpha = '0;
  logic [N_REQ*SCORE_W-1:0] req_minus_beta = '0;
  logic [N_REQ*TAG_W-1:0]   req_tag = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b1;
  logic [0:0]               resp_id;
  logic [TAG_W-1:0]         resp_tag;
  logic [SCORE_W-1:0]       resp_score;
  logic [1:0]               resp_err;
  logic [MATCH_W-1:0]       o_match;
  logic [SCORE_W-1:0]       o_mismatch;
  logic [SCORE_W-1:0]       o_minus_alpha;
  logic [SCORE_W-1:0]       o_minus_beta;
  logic                     o_start;
  logic                     i_busy = 1'b0;
  logic                     i_valid = 1'b0;
  logic [SCORE_W-1:0]       i_result = '0;
  logic                     o_abort_w;

  always #5 clk = ~clk;

  sw_job_scheduler #(
    .N_REQ(N_REQ), .MATCH_W(MATCH_W), .SCORE_W(SCORE_W), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_match(req_match), .req_mismatch(req_mismatch),
    .req_minus_alpha(req_minus_alpha), .req_minus_beta(req_minus_beta), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_tag(resp_tag),
    .resp_score(resp_score), .resp_err(resp_err),
    .o_match(o_match), .o_mismatch(o_mismatch), .o_minus_alpha(o_minus_alpha),
    .o_minus_beta(o_minus_beta), .o_start(o_start),
    .i_busy(i_busy), .i_valid(i_valid), .i_result(i_result)
`ifdef SW_SCHED_TIMEOUT_EN
   ,.o_abort(o_abort_w)
`endif
  );

`ifndef SW_SCHED_TIMEOUT_EN
  assign o_abort_w = 1'b0;
`endif

  typedef struct { int id; int tag; int score; int err; } exp_t;
  typedef struct { int m; int mm; int a; int b; } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   res_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0, acc_cyc = 0, acc_id = 0;
  int hs_cyc = 0, rise_cyc = 0;
  int start_cnt = 0, start_cyc = 0;
  int abort_cnt = 0, abort_cyc = 0;
  int array_lat = 3;
  bit array_en  = 1'b1;
  bit resp_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Response scoreboard, accept tracker, abort tracker.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("resp_id", resp_id, e.id);
          check("resp_tag", resp_tag, e.tag);
          check("resp_score", resp_score, e.score);
          check("resp_err", resp_err, e.err);
        end
      end
      if (|(req_valid & req_ready)) begin
        acc_cnt++;
        acc_cyc = cyc;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) acc_id = i;
      end
      if (resp_valid && !resp_prev) rise_cyc = cyc;
      if (o_abort_w) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
    resp_prev = resp_valid;
  end

  // Array model: checks start timing and the held config, then returns a result.
  initial forever begin
    cfg_t c;
    int   r;
    @(negedge clk);
    if (!rst && o_start) begin
      start_cnt++;
      start_cyc = cyc;
      check("start_after_accept", cyc - acc_cyc, 2);
      if (cfg_q.size() == 0) begin
        fail_now("start_unexpected");
      end else begin
        c = cfg_q.pop_front();
        check("o_match", o_match, c.m);
        check("o_mismatch", $signed(o_mismatch), c.mm);
        check("o_minus_alpha", $signed(o_minus_alpha), c.a);
        check("o_minus_beta", $signed(o_minus_beta), c.b);
      end
      if (array_en) begin
        r = (res_q.size() != 0) ? res_q.pop_front() : 0;
        repeat (array_lat) @(posedge clk);
        #1 i_valid = 1'b1;
        i_result = SCORE_W'(r);
        @(posedge clk);
        #1 i_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input int m, input int mm, input int a, input int b, input int tag);
    req_match[i*MATCH_W +: MATCH_W]       = MATCH_W'(m);
    req_mismatch[i*SCORE_W +: SCORE_W]    = SCORE_W'(mm);
    req_minus_alpha[i*SCORE_W +: SCORE_W] = SCORE_W'(a);
    req_minus_beta[i*SCORE_W +: SCORE_W]  = SCORE_W'(b);
    req_tag[i*TAG_W +: TAG_W]             = TAG_W'(tag);
    req_valid[i] = 1'b1;
  endtask

  task automatic push_job(input int id, input int tag, input int score, input int err);
    exp_t e;
    e.id = id; e.tag = tag; e.score = score; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg(input int m, input int mm, input int a, input int b);
    cfg_t c;
    c.m = m; c.mm = mm; c.a = a; c.b = b;
    cfg_q.push_back(c);
  endtask

  // Returns just after the edge that completes the n-th further accept.
  task automatic wait_accepts(input int n, input string name);
    int target = acc_cnt + n;
    int budget = 300;
    while (acc_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (acc_cnt < target) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget = 400;
    while ((exp_q.size() != 0 || resp_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) fail_now(name);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_resp_valid"}, resp_valid, 0);
    check({pfx, "_resp_id"}, resp_id, 0);
    check({pfx, "_resp_tag"}, resp_tag, 0);
    check({pfx, "_resp_score"}, resp_score, 0);
    check({pfx, "_resp_err"}, resp_err, 0);
    check({pfx, "_o_match"}, o_match, 0);
    check({pfx, "_o_mismatch"}, o_mismatch, 0);
    check({pfx, "_o_minus_alpha"}, o_minus_alpha, 0);
    check({pfx, "_o_minus_beta"}, o_minus_beta, 0);
    check({pfx, "_o_start"}, o_start, 0);
    check({pfx, "_o_abort"}, o_abort_w, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int budget;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single job from requester 0.
    set_req(0, 2, -1, -3, -1, 5);
    push_cfg(2, -1, -3, -1);
    res_q.push_back(42);
    push_job(0, 5, 42, 0);
    s0 = start_cnt;
    wait_accepts(1, "single_accept");
    req_valid = '0;
    drain("single_drain");
    check("single_start_count", start_cnt - s0, 1);

    // Parameter error from requester 1: alpha=-1 > beta=-3.
    set_req(1, 4, -1, -1, -3, 9);
    push_job(1, 9, 0, 2);
    s0 = start_cnt;
    wait_accepts(1, "perr_accept");
    req_valid = '0;
    drain("perr_drain");
    check("perr_start_count", start_cnt - s0, 0);
    check("perr_resp_latency", rise_cyc - acc_cyc, 2);

    // Round robin: both requesters held valid for four jobs.
    set_req(0, 3, -2, -5, -2, 1);
    set_req(1, 7, -4, -6, -3, 2);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_cfg(3, -2, -5, -2);
      else            push_cfg(7, -4, -6, -3);
      res_q.push_back(100 + k);
      push_job(k % 2, (k % 2 == 0) ? 1 : 2, 100 + k, 0);
    end
    wait_accepts(4, "rr_accept");
    req_valid = '0;
    drain("rr_drain");

    // Backpressure: response held while requester 1 waits.
    resp_ready = 1'b0;
    set_req(0, 1, 0, -2, -2, 3);
    set_req(1, 5, -1, -2, -1, 4);
    push_cfg(1, 0, -2, -2);
    push_cfg(5, -1, -2, -1);
    res_q.push_back(77);
    res_q.push_back(88);
    push_job(0, 3, 77, 0);
    push_job(1, 4, 88, 0);
    wait_accepts(1, "bp_accept");
    check("bp_first_grant", acc_id, 0);
    req_valid[0] = 1'b0;
    budget = 100;
    while (!resp_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!resp_valid) fail_now("bp_resp_wait");
    for (int k = 0; k < 10; k++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_score", resp_score, 77);
      check("bp_resp_tag", resp_tag, 3);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_accepts(1, "bp_second_accept");
    req_valid = '0;
    check("bp_second_grant", acc_id, 1);
    check("bp_back_to_back", acc_cyc - hs_cyc, 1);
    drain("bp_drain");

`ifdef SW_SCHED_TIMEOUT_EN
    // Watchdog: no result ever returned.
    array_en = 1'b0;
    set_req(0, 2, -1, -3, -1, 6);
    push_cfg(2, -1, -3, -1);
    push_job(0, 6, 0, 1);
    s0 = abort_cnt;
    wait_accepts(1, "to_accept");
    req_valid = '0;
    drain("to_drain");
    check("to_abort_count", abort_cnt - s0, 1);
    check("to_abort_delay", abort_cyc - (start_cyc + 1), 16);
    // Result arriving on the limit cycle wins.
    array_en  = 1'b1;
    array_lat = 16;
    set_req(1, 2, -1, -3, -1, 7);
    push_cfg(2, -1, -3, -1);
    res_q.push_back(55);
    push_job(1, 7, 55, 0);
    s0 = abort_cnt;
    wait_accepts(1, "to2_accept");
    req_valid = '0;
    drain("to2_drain");
    check("to2_abort_count", abort_cnt - s0, 0);
    array_lat = 3;
`endif

    // Reset while RUN: job dropped, requester 0 wins first afterwards.
    array_en = 1'b0;
    set_req(0, 2, -1, -3, -1, 8);
    push_cfg(2, -1, -3, -1);
    s0 = start_cnt;
    wait_accepts(1, "rst_accept");
    req_valid = '0;
    budget = 50;
    while (start_cnt == s0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (start_cnt == s0) fail_now("rst_start_wait");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    array_en = 1'b1;
    set_req(0, 3, -2, -4, -4, 10);
    set_req(1, 3, -2, -4, -4, 11);
    push_cfg(3, -2, -4, -4);
    res_q.push_back(60);
    push_job(0, 10, 60, 0);
    wait_accepts(1, "postrst_accept");
    req_valid = '0;
    check("postrst_grant", acc_id, 0);
    drain("postrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
